// File: rtl/wave_capture_ctrl_pkg.sv
// Shared types and constants for the waveform capture controller.
// The state encoding is fixed so the value can be probed during bring-up.
package wave_capture_ctrl_pkg;

  typedef enum logic [1:0] {
    ARMED  = 2'd0,
    ACTIVE = 2'd1,
    WAIT   = 2'd2
  } state_t;

  localparam int FRAME_LEN      = 256;
  localparam int RAM_DEPTH_LOG2 = 9;
  localparam int DISP_W         = 8;

endpackage

// File: rtl/wave_capture_ctrl_if.sv
// Sample source, sample RAM write port and display handshake of the capture controller.
// master = surrounding system side, slave = the capture controller.
interface wave_capture_ctrl_if #(
  parameter int SAMPLE_W = 16,
  parameter int DISP_W   = 8,
  parameter int CNT_W    = 8
);
  logic                new_sample_ready;
  logic [SAMPLE_W-1:0] new_sample_in;
  logic                wave_display_idle;
  logic [CNT_W:0]      write_address;
  logic                write_enable;
  logic [DISP_W-1:0]   write_sample;
  logic                read_index;

  modport master (
    output new_sample_ready, new_sample_in, wave_display_idle,
    input  write_address, write_enable, write_sample, read_index
  );

  modport slave (
    input  new_sample_ready, new_sample_in, wave_display_idle,
    output write_address, write_enable, write_sample, read_index
  );
endinterface

// File: rtl/wave_capture_ctrl_zero_cross.sv
// Positive-going zero-crossing detector: remembers the sign of the last strobed
// sample and pulses when a negative sample is followed by a non-negative one.
module zero_cross_detect (
  input  logic clk,
  input  logic reset,
  input  logic sample_ready,
  input  logic sample_sign,
  output logic crossing
);
  logic prev_neg;

  always_ff @(posedge clk) begin
    if (reset)
      prev_neg <= 1'b0;
    else if (sample_ready)
      prev_neg <= sample_sign;
  end

  assign crossing = sample_ready & prev_neg & ~sample_sign;
endmodule

// File: rtl/wave_capture_ctrl.sv
// Captures one frame of audio into the half of the sample RAM the display is
// not reading, starting at a positive zero crossing; swaps halves in blanking.
//
// state  | meaning
// ARMED  | waiting for a positive zero crossing
// ACTIVE | writing one sample per strobe until the frame is full
// WAIT   | frame complete, waiting for display idle to swap halves
module wave_capture_ctrl #(
  parameter int SAMPLE_W = 16,
  parameter int DISP_W   = 8,
  parameter int CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  wave_capture_ctrl_if.slave   cap
);
  import wave_capture_ctrl_pkg::*;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic             read_index, read_index_nxt;
  logic             crossing;
  logic             write_enable;

  zero_cross_detect u_zero_cross (
    .clk          (clk),
    .reset        (reset),
    .sample_ready (cap.new_sample_ready),
    .sample_sign  (cap.new_sample_in[SAMPLE_W-1]),
    .crossing     (crossing)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ARMED;
      count      <= '0;
      read_index <= 1'b0;
    end else begin
      state      <= state_nxt;
      count      <= count_nxt;
      read_index <= read_index_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    count_nxt      = count;
    read_index_nxt = read_index;
    write_enable   = 1'b0;
    case (state)
      ARMED: begin
        // the crossing sample only starts the frame, it is not stored
        if (crossing) begin
          state_nxt = ACTIVE;
          count_nxt = '0;
        end
      end
      ACTIVE: begin
        write_enable = cap.new_sample_ready;
        if (cap.new_sample_ready) begin
          count_nxt = count + 1'b1;
          if (count == '1)
            state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (cap.wave_display_idle) begin
          read_index_nxt = ~read_index;
          state_nxt      = ARMED;
        end
      end
      default: state_nxt = ARMED;
    endcase
  end

  // offset binary: flip the sign bit and keep the top magnitude bits
  assign cap.write_sample  = {~cap.new_sample_in[SAMPLE_W-1],
                              cap.new_sample_in[SAMPLE_W-2 -: DISP_W-1]};
  assign cap.write_address = {~read_index, count};
  assign cap.write_enable  = write_enable;
  assign cap.read_index    = read_index;
endmodule

// File: tb/tb_wave_capture_ctrl.sv
// Self-checking bench for wave_capture_ctrl against a frame-level reference model.
module tb_wave_capture_ctrl;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wave_capture_ctrl_if cap ();
  wave_capture_ctrl dut (.clk(clk), .reset(reset), .cap(cap));

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: 0 = waiting for crossing, 1 = capturing, 2 = frame done
  int         m_mode;
  int         m_n;
  logic       m_half;
  logic       m_prev;
  logic       exp_we;
  logic [8:0] exp_addr;
  logic [7:0] exp_ws;
  logic       exp_ri;
  int         s_val;

  task automatic drive(input logic rdy, input logic [15:0] smp, input logic idle);
    cap.new_sample_ready  = rdy;
    cap.new_sample_in     = smp;
    cap.wave_display_idle = idle;
    #1;
    s_val    = int'($signed(smp));
    exp_ws   = 8'((s_val + 32768) / 256);
    exp_we   = (m_mode == 1) && rdy;
    exp_addr = 9'((m_half ? 0 : 256) + m_n);
    exp_ri   = m_half;
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) begin
      m_mode = 0; m_n = 0; m_half = 1'b0; m_prev = 1'b0;
    end else begin
      case (m_mode)
        0: if (cap.new_sample_ready && m_prev && !cap.new_sample_in[15]) begin
             m_mode = 1; m_n = 0;
           end
        1: if (cap.new_sample_ready) begin
             m_n++;
             if (m_n == 256) begin m_mode = 2; m_n = 0; end
           end
        default: if (cap.wave_display_idle) begin
             m_half = !m_half; m_mode = 0;
           end
      endcase
      if (cap.new_sample_ready) m_prev = cap.new_sample_in[15];
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 16'h0000, 1'b0);
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    drive(1'b0, 16'h0000, 1'b0);
    n_checks++;
    if (cap.write_enable !== 1'b0) begin n_fail++;
      $display("FAIL reset_we got %b expected 0", cap.write_enable); end
    n_checks++;
    if (cap.write_address !== 9'h100) begin n_fail++;
      $display("FAIL reset_addr got %h expected 100", cap.write_address); end
    n_checks++;
    if (cap.read_index !== 1'b0) begin n_fail++;
      $display("FAIL reset_ri got %b expected 0", cap.read_index); end
  endtask

  task automatic test_no_crossing();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 16'h0000, 1'b0);
      n_checks++;
      if (cap.write_enable !== 1'b0 || cap.read_index !== 1'b0) begin n_fail++;
        $display("FAIL no_cross cyc %0d got we=%b ri=%b expected we=0 ri=0",
                 i, cap.write_enable, cap.read_index); end
      tick();
    end
  endtask

  task automatic test_arm_first_write();
    drive(1'b1, 16'hC000, 1'b0);
    n_checks++;
    if (cap.write_enable !== 1'b0) begin n_fail++;
      $display("FAIL arm_neg_we got %b expected 0", cap.write_enable); end
    tick();
    drive(1'b1, 16'h1234, 1'b0);
    n_checks++;
    if (cap.write_enable !== 1'b0) begin n_fail++;
      $display("FAIL arm_cross_we got %b expected 0", cap.write_enable); end
    tick();
    drive(1'b1, 16'h2492, 1'b0);
    n_checks++;
    if (cap.write_enable !== 1'b1 || cap.write_address !== 9'h100 ||
        cap.write_sample !== 8'hA4) begin n_fail++;
      $display("FAIL first_write got we=%b addr=%h ws=%h expected we=1 addr=100 ws=a4",
               cap.write_enable, cap.write_address, cap.write_sample); end
    tick();
  endtask

  task automatic test_full_frame();
    logic [8:0] last_addr;
    int         guard;
    last_addr = 9'h000;
    guard     = 0;
    while (m_mode == 1 && guard < 2000) begin
      drive(1'($urandom_range(0, 3) != 0), 16'($urandom), 1'($urandom_range(0, 1)));
      n_checks++;
      if (cap.write_enable !== exp_we || (exp_we && cap.write_address !== exp_addr) ||
          cap.write_sample !== exp_ws) begin n_fail++;
        $display("FAIL frame cyc %0d got we=%b addr=%h ws=%h expected we=%b addr=%h ws=%h",
                 guard, cap.write_enable, cap.write_address, cap.write_sample,
                 exp_we, exp_addr, exp_ws); end
      if (cap.write_enable === 1'b1) last_addr = cap.write_address;
      tick();
      guard++;
    end
    n_checks++;
    if (guard >= 2000) begin n_fail++;
      $display("FAIL frame_timeout got %0d cycles expected < 2000", guard); end
    n_checks++;
    if (last_addr !== 9'h1FF) begin n_fail++;
      $display("FAIL frame_last_addr got %h expected 1ff", last_addr); end
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 16'($urandom), 1'b0);
      n_checks++;
      if (cap.write_enable !== 1'b0) begin n_fail++;
        $display("FAIL wait_we cyc %0d got %b expected 0", i, cap.write_enable); end
      tick();
    end
  endtask

  task automatic test_wait_flip();
    for (int i = 0; i < 100; i++) begin
      drive(1'($urandom_range(0, 1)), 16'($urandom), 1'b0);
      tick();
    end
    drive(1'b0, 16'h0000, 1'b1);
    n_checks++;
    if (cap.read_index !== 1'b0) begin n_fail++;
      $display("FAIL flip_before got %b expected 0", cap.read_index); end
    tick();
    drive(1'b0, 16'h0000, 1'b0);
    n_checks++;
    if (cap.read_index !== 1'b1) begin n_fail++;
      $display("FAIL flip_after got %b expected 1", cap.read_index); end
  endtask

  task automatic test_random_frames();
    logic [15:0] smp;
    for (int i = 0; i < 2500; i++) begin
      smp = 16'($urandom);
      drive(1'($urandom_range(0, 2) != 0), smp, 1'($urandom_range(0, 9) == 0));
      n_checks++;
      if (cap.write_enable !== exp_we || (exp_we && cap.write_address !== exp_addr) ||
          cap.write_sample !== exp_ws || cap.read_index !== exp_ri) begin n_fail++;
        $display("FAIL rand cyc %0d got we=%b addr=%h ws=%h ri=%b expected we=%b addr=%h ws=%h ri=%b",
                 i, cap.write_enable, cap.write_address, cap.write_sample, cap.read_index,
                 exp_we, exp_addr, exp_ws, exp_ri); end
      tick();
    end
  endtask

  task automatic test_conversion();
    logic [15:0] smp_tab [4] = '{16'h8000, 16'hFFFF, 16'h7FFF, 16'h0000};
    logic [7:0]  ws_tab  [4] = '{8'h00, 8'h7F, 8'hFF, 8'h80};
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, smp_tab[i], 1'b0);
      n_checks++;
      if (cap.write_sample !== ws_tab[i] || cap.write_sample !== exp_ws) begin n_fail++;
        $display("FAIL conv %h got %h expected %h", smp_tab[i], cap.write_sample, ws_tab[i]); end
    end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    drive(1'b1, 16'h8000, 1'b0); tick();
    drive(1'b1, 16'h0100, 1'b0); tick();
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, (i == 99) ? 16'h8000 : 16'($urandom), 1'b1);
      n_checks++;
      if (cap.write_enable !== 1'b1 || cap.write_address !== 9'(9'h100 + i)) begin n_fail++;
        $display("FAIL mid_write %0d got we=%b addr=%h expected we=1 addr=%h",
                 i, cap.write_enable, cap.write_address, 9'(9'h100 + i)); end
      tick();
    end
    reset = 1'b1;
    drive(1'b1, 16'h0100, 1'b0);
    tick();
    reset = 1'b0;
    drive(1'b1, 16'h1000, 1'b0);
    n_checks++;
    if (cap.write_enable !== 1'b0 || cap.write_address !== 9'h100 ||
        cap.read_index !== 1'b0) begin n_fail++;
      $display("FAIL mid_reset got we=%b addr=%h ri=%b expected we=0 addr=100 ri=0",
               cap.write_enable, cap.write_address, cap.read_index); end
    tick();
    drive(1'b1, 16'h1000, 1'b0);
    n_checks++;
    if (cap.write_enable !== 1'b0 || cap.write_enable !== exp_we) begin n_fail++;
      $display("FAIL mid_rearm_we got %b expected 0", cap.write_enable); end
    tick();
  endtask

  initial begin
    m_mode = 0; m_n = 0; m_half = 1'b0; m_prev = 1'b0;
    reset = 1'b1;
    cap.new_sample_ready  = 1'b0;
    cap.new_sample_in     = 16'h0000;
    cap.wave_display_idle = 1'b0;
    @(negedge clk);
    test_reset();
    test_no_crossing();
    test_arm_first_write();
    test_full_frame();
    test_wait_flip();
    test_random_frames();
    test_conversion();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/wave_capture_ctrl.md
Name: wave_capture_ctrl

Overview:
- Captures one 256-sample frame of a signed 16-bit audio stream, triggered on a positive-going zero crossing.
- Writes the frame into one half of a 512-entry, 8-bit, 1-write/2-read sample RAM while the display reads the other half.
- Sits between the audio sample source and the sample RAM / wave display.
- Flips the active half (read_index) only when the display reports idle (vertical blanking).

Parameters:
- SAMPLE_W, 16, width of the incoming signed sample.
- DISP_W, 8, width of the stored display sample.
- CNT_W, 8, per-frame sample counter width; frame length is 2**CNT_W = 256.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- new_sample_ready  in  1  sample strobe; every cycle it is high counts as one new sample.
- new_sample_in  in  SAMPLE_W  signed two's-complement sample, valid when the strobe is high.
- wave_display_idle  in  1  high while the display is not scanning (driven from ~vsync).
- write_address  out  CNT_W+1  RAM write address = {~read_index, count}.
- write_enable  out  1  RAM write strobe.
- write_sample  out  DISP_W  offset-binary sample = {~new_sample_in[15], new_sample_in[14:8]}.
- read_index  out  1  RAM half the display reads; the capture side writes half ~read_index.

Behaviour:
- Registers: state (ARMED, ACTIVE, WAIT), count[7:0], read_index, prev_neg (sign bit of the last strobed sample).
- Reset values: state=ARMED, count=0, read_index=0, prev_neg=0.
- Reset values of outputs: write_enable=0, write_address=9'h100, write_sample follows its input combinationally.
- prev_neg <= new_sample_in[15] on every cycle with new_sample_ready=1, in all states.
- ARMED:
  - A positive zero crossing is new_sample_ready & prev_neg & ~new_sample_in[15].
  - On a crossing: go to ACTIVE, count <= 0.
  - The crossing sample itself is not written.
- ACTIVE:
  - write_enable = new_sample_ready (combinational, same cycle as the strobe).
  - On each write: count <= count+1.
  - On the write where count==255: go to WAIT. count wraps to 0.
  - Exactly 256 writes per frame, addresses {~read_index, 8'h00} through {~read_index, 8'hFF}.
- WAIT:
  - No writes.
  - When wave_display_idle=1: read_index <= ~read_index, go to ARMED.
  - The flip takes effect for the display on the next cycle.
- write_enable is 0 in ARMED and WAIT.
- write_address and write_sample are combinational from the current registers and inputs.
- Latency: a sample strobed in ACTIVE is written the same cycle. read_index toggles 1 cycle after idle is seen in WAIT.
- Boundary conditions:
  - Strobe held high for N cycles = N samples.
  - A crossing and a strobe in the same cycle: the crossing wins, that sample is not written.
  - wave_display_idle is ignored outside WAIT, so read_index never changes mid-frame.
  - Reset mid-frame aborts the frame. Partial RAM contents are left as is (the RAM is not cleared).
  - Sample 16'h8000 maps to 8'h00, 16'h0000 maps to 8'h80, 16'h7FFF maps to 8'hFF.

Decomposition:
- Shared package holds:
  - the state encoding enum (ARMED=0, ACTIVE=1, WAIT=2)
  - the constants FRAME_LEN=256, RAM_DEPTH_LOG2=9, DISP_W=8.
- A small sub-module, zero_cross_detect, is natural: it holds the prev_neg register and outputs the crossing pulse.
- The RAM (ram_1w2r) and the DVI timing block are separate, existing modules and are not part of this block.

Test Plan:
- Reset, then new_sample_ready=1 with 16'h0000 constant -> no crossing (prev_neg=0); write_enable stays 0; read_index=0.
- Strobe 16'hC000 then 16'h1234 -> ARMED to ACTIVE on the 16'h1234 cycle, no write that cycle. Next strobe 16'h2492 -> write_enable=1, address 9'h100, write_sample 8'hA4.
- 256 consecutive strobes in ACTIVE -> addresses 9'h100 through 9'h1FF, then state=WAIT and write_enable=0 even with the strobe held high.
- In WAIT, wave_display_idle=0 for 100 cycles then 1 -> read_index goes 0 to 1 one cycle after idle rises. The next frame writes 9'h000 through 9'h0FF.
- Conversion checks: 16'h8000 -> 8'h00; 16'hFFFF -> 8'h7F; 16'h7FFF -> 8'hFF.
- Reset asserted after 100 writes -> state=ARMED, count=0, read_index=0, write_enable=0 on the next cycle.
